// File: rtl/permute_pkg.sv
// Shared types and constants for the decoder inverse-pi stage.
// Holds slice width, default frame length, FSM states and the buffer slot layout.
// inv_pi_src gives, for each output bit, the input bit it is taken from.
package permute_pkg;

  localparam int SLICE_W   = 25;
  localparam int LINES_DEF = 64;
  localparam int CNT_W     = 7;
  localparam int IDX_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [SLICE_W-1:0] data;
    logic [IDX_W-1:0]   index;
    logic               last;
  } slot_t;

  // Output bit u + 5v is sourced from input bit v + 5*((2*(u - v)) mod 5).
  // The +5 keeps the difference non-negative before the modulo.
  function automatic int inv_pi_src(input int k);
    int u;
    int v;
    u = k % 5;
    v = k / 5;
    return v + 5 * ((2 * (u - v + 5)) % 5);
  endfunction

endpackage

// File: rtl/inv_permutation.sv
// Purpose: inverse pi lane permutation of one 25-bit slice (pure wiring).
// Latency: combinational, zero cycles.
// Backpressure: none; the instantiating block owns flow control.
module inv_permutation
  import permute_pkg::*;
(
  input  logic [SLICE_W-1:0] src,
  output logic [SLICE_W-1:0] dst
);

  genvar k;
  for (k = 0; k < SLICE_W; k++) begin : g_bit
    localparam int SRC_BIT = inv_pi_src(k);
    assign dst[k] = src[SRC_BIT];
  end

endmodule

// File: rtl/inv_permute_unit.sv
// Purpose: frame-level inverse pi stage; permutes LINES slices and tags index/last.
// Latency: one cycle from input acceptance to out_valid when the buffer is empty.
// Backpressure: 2-entry skid buffer; in_ready is registered, no path from out_ready.
module inv_permute_unit
  import permute_pkg::*;
#(
  parameter int LINES = LINES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SLICE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_data,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] LINES_C = CNT_W'(LINES);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LINES - 1);

  state_t             state;
  logic [CNT_W-1:0]   in_count;
  logic [CNT_W-1:0]   out_count;
  logic [CNT_W-1:0]   out_count_nxt;
  slot_t              slot_q [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         entries;
  logic [1:0]         entries_nxt;
  logic               push;
  logic               pop;
  logic [SLICE_W-1:0] perm_data;
  slot_t              wr_slot;

  inv_permutation u_inv_permutation (
    .src (in_data),
    .dst (perm_data)
  );

  assign out_valid = (entries != 2'd0);
  assign out_data  = slot_q[rd_ptr].data;
  assign out_index = slot_q[rd_ptr].index;
  assign out_last  = slot_q[rd_ptr].last;

  // Handshakes and next-cycle occupancy; in_ready is only ever high in RUN.
  always_comb begin
    push          = in_valid && in_ready;
    pop           = out_valid && out_ready;
    entries_nxt   = entries + 2'(push) - 2'(pop);
    out_count_nxt = out_count + CNT_W'(pop);
    wr_slot.data  = perm_data;
    wr_slot.index = in_count[IDX_W-1:0];
    wr_slot.last  = (in_count == LAST_C);
  end

  // Frame FSM, counters, skid buffer and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      in_count  <= '0;
      out_count <= '0;
      entries   <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      entries <= entries_nxt;
      if (push) begin
        slot_q[wr_ptr] <= wr_slot;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        out_count <= out_count_nxt;
      end
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            in_count  <= '0;
            out_count <= '0;
            busy      <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (push) begin
            in_count <= in_count + CNT_W'(1);
          end
          if (push && in_count == LAST_C) begin
            state    <= ST_DRAIN;
            in_ready <= 1'b0;
          end else begin
            in_ready <= (entries_nxt != 2'd2);
          end
        end
        ST_DRAIN: begin
          if (entries_nxt == 2'd0 && out_count_nxt == LINES_C) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
